// File: rtl/core_pkg.sv
// Shared core definitions: hazard FSM states, redirect-source encoding and
// write-back select constants used across the pipeline.
package core_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_FLUSH    = 2'd2
   } hz_state_e;

   typedef enum logic [1:0] {
      RDR_NONE = 2'd0,
      RDR_TRAP = 2'd1,
      RDR_JMP  = 2'd2,
      RDR_BR   = 2'd3
   } rdr_src_e;

   localparam logic [2:0]  WB_X      = 3'd0;
   localparam logic [2:0]  WB_ALU    = 3'd1;
   localparam logic [2:0]  WB_MEM    = 3'd2;
   localparam logic [2:0]  WB_PC     = 3'd3;
   localparam logic [2:0]  WB_CSR    = 3'd4;
   localparam logic [31:0] REGPC_NOP = 32'h0000_0013;

   // Trap beats a memory-stage jump, which beats an execute-stage branch.
   function automatic rdr_src_e rdr_pick(input logic trap, input logic jmp, input logic br);
      rdr_src_e src;
      src = RDR_NONE;
      if (trap)
         src = RDR_TRAP;
      else if (jmp)
         src = RDR_JMP;
      else if (br)
         src = RDR_BR;
      return src;
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Wrapping stall-cycle and redirect counters for the hazard controller.
module hazard_perf_cnt
   import core_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall_inc,
   input  logic             flush_inc,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   always_comb begin
      stall_d = stall_inc ? stall_q + ONE : stall_q;
      flush_d = flush_inc ? flush_q + ONE : flush_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use stalls, memory waits, and redirects from
// traps, jumps and branches, with performance counters.
module pipeline_hazard_ctrl
   import core_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_rs1_use,
   input  logic             id_rs2_use,
   input  logic             ex_rf_wen,
   input  logic             ex_is_load,
   input  logic [4:0]       ex_wb_addr,
   input  logic             ex_br_flg,
   input  logic [31:0]      ex_br_target,
   input  logic             mem_jmp_flg,
   input  logic [31:0]      mem_jmp_target,
   input  logic             trap_req,
   input  logic [31:0]      trap_vector,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             if_stall,
   output logic             id_stall,
   output logic             stall_flg,
   output logic             ex_bubble,
   output logic             branch_hazard,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   hz_state_e   state_q, state_d;
   logic [3:0]  flush_cnt_q, flush_cnt_d;
   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        branch_hazard_q, branch_hazard_d;
   logic        mem_stall_q, mem_stall_d;

   rdr_src_e    src;
   logic        take;
   logic        load_use;

   always_comb begin
      src              = rdr_pick(trap_req, mem_jmp_flg, ex_br_flg);
      take             = 1'b0;
      state_d          = state_q;
      flush_cnt_d      = flush_cnt_q;
      redirect_pc_d    = redirect_pc_q;
      redirect_valid_d = 1'b0;
      branch_hazard_d  = 1'b0;
      mem_stall_d      = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (src != RDR_NONE)
               take = 1'b1;
            else if (mem_req && !mem_ready) begin
               state_d     = ST_MEM_WAIT;
               mem_stall_d = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready)
               state_d = ST_RUN;
            else
               mem_stall_d = 1'b1;
         end
         ST_FLUSH: begin
            // Only a trap can re-arm; branch/jump here belong to squashed work.
            if (trap_req)
               take = 1'b1;
            else if (flush_cnt_q == 4'd0)
               state_d = ST_RUN;
            else begin
               flush_cnt_d     = flush_cnt_q - 4'd1;
               branch_hazard_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase

      if (take) begin
         state_d          = ST_FLUSH;
         flush_cnt_d      = FLUSH_RELOAD;
         redirect_valid_d = 1'b1;
         branch_hazard_d  = 1'b1;
         case (src)
            RDR_TRAP: redirect_pc_d = trap_vector;
            RDR_JMP:  redirect_pc_d = mem_jmp_target;
            RDR_BR:   redirect_pc_d = ex_br_target;
            default:  redirect_pc_d = redirect_pc_q;
         endcase
      end

      load_use = (state_q == ST_RUN) && (src == RDR_NONE) && id_valid && ex_is_load
                 && ex_rf_wen && (ex_wb_addr != 5'd0)
                 && ((id_rs1_use && (id_rs1_addr == ex_wb_addr))
                  || (id_rs2_use && (id_rs2_addr == ex_wb_addr)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_RUN;
         flush_cnt_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         branch_hazard_q  <= 1'b0;
         mem_stall_q      <= 1'b0;
      end else begin
         state_q          <= state_d;
         flush_cnt_q      <= flush_cnt_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         branch_hazard_q  <= branch_hazard_d;
         mem_stall_q      <= mem_stall_d;
      end
   end

   assign if_stall       = mem_stall_q | load_use;
   assign id_stall       = mem_stall_q | load_use;
   assign stall_flg      = mem_stall_q;
   assign ex_bubble      = load_use;
   assign branch_hazard  = branch_hazard_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

   hazard_perf_cnt #(
      .CNT_W (CNT_W)
   ) u_perf_cnt (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_inc    (if_stall),
      .flush_inc    (take),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: cycle-indexed reference model plus directed
// sequences with literal expectations.
module tb_pipeline_hazard_ctrl;

   localparam int FC = 2;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid, id_rs1_use, id_rs2_use;
   logic [4:0]    id_rs1_addr, id_rs2_addr, ex_wb_addr;
   logic          ex_rf_wen, ex_is_load, ex_br_flg, mem_jmp_flg, trap_req;
   logic [31:0]   ex_br_target, mem_jmp_target, trap_vector;
   logic          mem_req, mem_ready;
   logic          if_stall, id_stall, stall_flg, ex_bubble, branch_hazard, redirect_valid;
   logic [31:0]   redirect_pc;
   logic [CW-1:0] stall_cycles, flush_count;

   pipeline_hazard_ctrl #(
      .FLUSH_CYCLES (FC),
      .CNT_W        (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .id_valid       (id_valid),
      .id_rs1_addr    (id_rs1_addr),
      .id_rs2_addr    (id_rs2_addr),
      .id_rs1_use     (id_rs1_use),
      .id_rs2_use     (id_rs2_use),
      .ex_rf_wen      (ex_rf_wen),
      .ex_is_load     (ex_is_load),
      .ex_wb_addr     (ex_wb_addr),
      .ex_br_flg      (ex_br_flg),
      .ex_br_target   (ex_br_target),
      .mem_jmp_flg    (mem_jmp_flg),
      .mem_jmp_target (mem_jmp_target),
      .trap_req       (trap_req),
      .trap_vector    (trap_vector),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .if_stall       (if_stall),
      .id_stall       (id_stall),
      .stall_flg      (stall_flg),
      .ex_bubble      (ex_bubble),
      .branch_hazard  (branch_hazard),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_cycles   (stall_cycles),
      .flush_count    (flush_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit run_cmp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks cycle numbers of redirect pulse and end of flush window.
   int          cyc, bh_end, rv_cycle, exp_stalls, exp_flushes;
   bit          waiting;
   logic [31:0] exp_pc;

   function automatic bit any_src();
      return trap_req || mem_jmp_flg || ex_br_flg;
   endfunction

   function automatic bit hazard();
      return id_valid && ex_is_load && ex_rf_wen && (ex_wb_addr != 0)
             && ((id_rs1_use && id_rs1_addr == ex_wb_addr) || (id_rs2_use && id_rs2_addr == ex_wb_addr));
   endfunction

   function automatic bit m_flushing();
      return cyc <= bh_end;
   endfunction

   function automatic bit m_lu();
      return rst_n && !m_flushing() && !waiting && !any_src() && hazard();
   endfunction

   task automatic m_redirect(input logic [31:0] pc);
      rv_cycle = cyc + 1;
      bh_end   = cyc + FC;
      exp_pc   = pc;
      exp_flushes++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc = 0; bh_end = -1; rv_cycle = -1; waiting = 1'b0;
         exp_pc = '0; exp_stalls = 0; exp_flushes = 0;
      end else begin
         if (waiting || m_lu()) exp_stalls++;
         if (m_flushing()) begin
            if (trap_req) m_redirect(trap_vector);
         end else if (waiting) begin
            if (mem_ready) waiting = 1'b0;
         end else if (any_src()) begin
            m_redirect(trap_req ? trap_vector : mem_jmp_flg ? mem_jmp_target : ex_br_target);
         end else if (mem_req && !mem_ready) begin
            waiting = 1'b1;
         end
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("m_if_stall",  if_stall,       32'(waiting || m_lu()));
         chk("m_id_stall",  id_stall,       32'(waiting || m_lu()));
         chk("m_stall_flg", stall_flg,      32'(waiting));
         chk("m_ex_bubble", ex_bubble,      32'(m_lu()));
         chk("m_br_hazard", branch_hazard,  32'(rst_n && m_flushing()));
         chk("m_redir_v",   redirect_valid, 32'(rst_n && cyc == rv_cycle));
         chk("m_redir_pc",  redirect_pc,    exp_pc);
         chk("m_stall_cnt", 32'(stall_cycles), 32'(exp_stalls % (1 << CW)));
         chk("m_flush_cnt", 32'(flush_count),  32'(exp_flushes % (1 << CW)));
         if (stall_flg && branch_hazard) chk("excl_stall_bh", 32'd1, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_use = 0; id_rs2_use = 0;
      ex_rf_wen = 0; ex_is_load = 0; ex_wb_addr = 0;
      ex_br_flg = 0; ex_br_target = 0; mem_jmp_flg = 0; mem_jmp_target = 0;
      trap_req = 0; trap_vector = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic load_use_x(input logic [4:0] rd);
      ex_is_load = 1; ex_rf_wen = 1; ex_wb_addr = rd;
      id_valid = 1; id_rs2_use = 1; id_rs2_addr = rd; id_rs1_use = 1; id_rs1_addr = 5'd7;
   endtask

   task automatic do_reset();
      tick();
      idle();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   initial begin
      idle();
      rst_n = 0;
      tick();
      run_cmp = 1'b1;
      at_neg();
      chk("rst_redir_pc", redirect_pc, 32'h0);
      chk("rst_flush_cnt", 32'(flush_count), 32'd0);
      tick();
      rst_n = 1;

      // Load-use on x5 via rs2, then the same with x0
      tick(); load_use_x(5'd5);
      at_neg();
      chk("lu_if_stall", if_stall, 1); chk("lu_bubble", ex_bubble, 1); chk("lu_stall_flg", stall_flg, 0);
      tick(); idle();
      at_neg();
      chk("lu_one_cycle", if_stall, 0); chk("lu_stall_cnt", 32'(stall_cycles), 1);
      load_use_x(5'd0);
      at_neg();
      chk("lu_x0_none", if_stall, 0); chk("lu_x0_bubble", ex_bubble, 0);

      // Branch to 0x100, with a load-use hazard present in the same cycle
      do_reset();
      tick(); ex_br_flg = 1; ex_br_target = 32'h100; load_use_x(5'd5);
      at_neg();
      chk("br_overrides_lu", if_stall, 0); chk("br_pre_rv", redirect_valid, 0);
      tick(); idle();
      at_neg();
      chk("br_rv", redirect_valid, 1); chk("br_pc", redirect_pc, 32'h100);
      chk("br_bh1", branch_hazard, 1); chk("br_fc", 32'(flush_count), 1);
      tick(); at_neg();
      chk("br_rv_once", redirect_valid, 0); chk("br_bh2", branch_hazard, 1);
      tick(); at_neg();
      chk("br_bh_end", branch_hazard, 0);

      // Priority: trap > branch, then jump > branch
      do_reset();
      tick(); trap_req = 1; trap_vector = 32'h80; ex_br_flg = 1; ex_br_target = 32'h100;
      tick(); idle();
      at_neg(); chk("prio_trap", redirect_pc, 32'h80);
      tick(); tick();
      mem_jmp_flg = 1; mem_jmp_target = 32'h200; ex_br_flg = 1; ex_br_target = 32'h100;
      tick(); idle();
      at_neg(); chk("prio_jmp", redirect_pc, 32'h200); chk("prio_fc", 32'(flush_count), 2);
      tick(); tick();

      // Memory wait with a branch pulsed while held
      do_reset();
      tick(); mem_req = 1; mem_ready = 0;
      at_neg(); chk("mw_c0_nostall", if_stall, 0);
      tick(); at_neg(); chk("mw_c1_stall", stall_flg, 1); chk("mw_c1_if", if_stall, 1);
      tick(); ex_br_flg = 1; ex_br_target = 32'h100;
      at_neg(); chk("mw_br_ignored_now", redirect_valid, 0);
      tick(); ex_br_flg = 0;
      at_neg(); chk("mw_c3_rv", redirect_valid, 0);
      tick(); mem_ready = 1;
      at_neg(); chk("mw_c4_stall", stall_flg, 1);
      tick(); idle();
      at_neg();
      chk("mw_drop", stall_flg, 0); chk("mw_drop_if", if_stall, 0);
      chk("mw_no_rv", redirect_valid, 0); chk("mw_stall_cnt", 32'(stall_cycles), 4);
      ex_br_flg = 1; ex_br_target = 32'h104;
      tick(); idle();
      at_neg(); chk("mw_after_rv", redirect_valid, 1); chk("mw_after_pc", redirect_pc, 32'h104);
      tick(); tick();

      // Branch ignored during flush, trap re-arms it
      do_reset();
      tick(); ex_br_flg = 1; ex_br_target = 32'h100;
      tick(); idle(); ex_br_flg = 1; ex_br_target = 32'h300;
      at_neg(); chk("fl_bh_a", branch_hazard, 1);
      tick(); idle(); trap_req = 1; trap_vector = 32'h80;
      at_neg(); chk("fl_br_ignored", redirect_valid, 0); chk("fl_fc1", 32'(flush_count), 1);
      tick(); idle();
      at_neg();
      chk("fl_trap_rv", redirect_valid, 1); chk("fl_trap_pc", redirect_pc, 32'h80);
      chk("fl_fc2", 32'(flush_count), 2); chk("fl_bh_b", branch_hazard, 1);
      tick(); at_neg(); chk("fl_bh_ext", branch_hazard, 1);
      tick(); at_neg(); chk("fl_bh_done", branch_hazard, 0);

      // Asynchronous reset in the middle of a flush
      do_reset();
      tick(); ex_br_flg = 1; ex_br_target = 32'h100;
      tick(); idle();
      rst_n = 0;
      #1;
      chk("ar_bh", branch_hazard, 0); chk("ar_rv", redirect_valid, 0);
      chk("ar_pc", redirect_pc, 32'h0); chk("ar_fc", 32'(flush_count), 0);
      chk("ar_stall", if_stall, 0);
      tick(); tick();
      rst_n = 1;
      at_neg(); chk("ar_post_bh", branch_hazard, 0);
      tick(); ex_br_flg = 1; ex_br_target = 32'h40;
      tick(); idle();
      at_neg(); chk("ar_run_rv", redirect_valid, 1); chk("ar_run_pc", redirect_pc, 32'h40);
      tick(); tick();

      // Long memory wait: 20 stall cycles wraps a 4-bit counter to 4
      do_reset();
      tick(); mem_req = 1; mem_ready = 0;
      repeat (20) tick();
      mem_ready = 1;
      tick(); idle();
      at_neg(); chk("wrap_stall_cnt", 32'(stall_cycles), 4); chk("wrap_if", if_stall, 0);

      // Mixed traffic, checked by the model only
      for (int i = 0; i < 300; i++) begin
         tick();
         idle();
         id_valid    = ($urandom_range(0, 3) != 0);
         id_rs1_addr = 5'($urandom_range(0, 3));
         id_rs2_addr = 5'($urandom_range(0, 3));
         id_rs1_use  = 1'($urandom_range(0, 1));
         id_rs2_use  = 1'($urandom_range(0, 1));
         ex_rf_wen   = 1'($urandom_range(0, 1));
         ex_is_load  = 1'($urandom_range(0, 1));
         ex_wb_addr  = 5'($urandom_range(0, 3));
         ex_br_flg   = ($urandom_range(0, 9) == 0);
         ex_br_target   = $urandom;
         mem_jmp_flg = ($urandom_range(0, 14) == 0);
         mem_jmp_target = $urandom;
         trap_req    = ($urandom_range(0, 19) == 0);
         trap_vector = $urandom;
         mem_req     = ($urandom_range(0, 4) == 0);
         mem_ready   = 1'($urandom_range(0, 1));
      end
      tick(); idle();
      tick(); tick();
      at_neg();
      run_cmp = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
